// File: rtl/fetch_pkg.sv
// Shared types and address-geometry helpers for the instruction-fetch cache.
package fetch_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    MISS_REQ  = 2'd1,
    MISS_WAIT = 2'd2
  } fetch_state_e;

  // Byte-offset bits within a line (includes the 2 byte-in-word bits).
  function automatic int off_w(input int line_words);
    return 2 + $clog2(line_words);
  endfunction

  function automatic int idx_w(input int num_lines);
    return $clog2(num_lines);
  endfunction

  function automatic int tag_w(input int line_words, input int num_lines);
    return WORD_W - off_w(line_words) - idx_w(num_lines);
  endfunction

endpackage

// File: rtl/fetch_cache_unit_array.sv
// Direct-mapped cache storage: valid bits, tags and line data with
// combinational read by index and a single synchronous line-write port.
module icache_array
  import fetch_pkg::*;
#(
  parameter int LINE_WORDS = 4,
  parameter int NUM_LINES  = 16,
  localparam int IDX_W  = idx_w(NUM_LINES),
  localparam int TAG_W  = tag_w(LINE_WORDS, NUM_LINES),
  localparam int LINE_W = WORD_W * LINE_WORDS
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic [IDX_W-1:0]  rd_idx_i,
  output logic              rd_valid_o,
  output logic [TAG_W-1:0]  rd_tag_o,
  output logic [LINE_W-1:0] rd_line_o,
  input  logic              wr_en_i,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic [TAG_W-1:0]  wr_tag_i,
  input  logic [LINE_W-1:0] wr_line_i
);

  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
  logic [LINE_W-1:0]    data_mem [NUM_LINES];

  // Only the valid bits are cleared; stale tags/data are masked by them.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      valid_q <= '0;
    end else if (wr_en_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (wr_en_i) begin
      tag_mem[wr_idx_i]  <= wr_tag_i;
      data_mem[wr_idx_i] <= wr_line_i;
    end
  end

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_mem[rd_idx_i];
  assign rd_line_o  = data_mem[rd_idx_i];

endmodule

// File: rtl/fetch_cache_unit.sv
// Instruction fetch stage: PC, next-PC select, direct-mapped I-cache and line-refill FSM.
// Optional hit/miss performance counters are enabled by defining FETCH_PERF_CNT_EN.
module fetch_cache_unit
  import fetch_pkg::*;
#(
  parameter int          LINE_WORDS = 4,
  parameter int          NUM_LINES  = 16,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                           Clk,
  input  logic                           Rst_n,
  input  logic                           PCSrc,
  input  logic [31:0]                    branchTarget,
  input  logic                           stall,
  output logic [31:0]                    inst,
  output logic [31:0]                    pcOut,
  output logic                           instValid,
  output logic                           hit,
  output logic                           memReq,
  output logic [31:0]                    memAddr,
  input  logic                           memReady,
  input  logic                           memValid,
  input  logic [WORD_W*LINE_WORDS-1:0]   memData
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]                    hitCount,
  output logic [31:0]                    missCount
`endif
);

  localparam int OFF_W  = off_w(LINE_WORDS);
  localparam int IDX_W  = idx_w(NUM_LINES);
  localparam int TAG_W  = tag_w(LINE_WORDS, NUM_LINES);
  localparam int WSEL_W = OFF_W - 2;
  localparam int LINE_W = WORD_W * LINE_WORDS;

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  mem_addr_q, mem_addr_d;
  logic         mem_req_q, mem_req_d;

  logic [IDX_W-1:0]  pc_idx, fill_idx;
  logic [TAG_W-1:0]  pc_tag, fill_tag, rd_tag;
  logic [WSEL_W-1:0] pc_word;
  logic              rd_valid, tag_hit, fill_en;
  logic [LINE_W-1:0] rd_line;
  logic [WORD_W-1:0] line_words [LINE_WORDS];
  logic              unused_bt;

  assign pc_idx   = pc_q[OFF_W+IDX_W-1:OFF_W];
  assign pc_word  = pc_q[OFF_W-1:2];
  assign pc_tag   = pc_q[31:OFF_W+IDX_W];
  assign fill_idx = mem_addr_q[OFF_W+IDX_W-1:OFF_W];
  assign fill_tag = mem_addr_q[31:OFF_W+IDX_W];
  assign fill_en  = (state_q == MISS_WAIT) && memValid;
  assign unused_bt = ^branchTarget[1:0];

  icache_array #(
    .LINE_WORDS (LINE_WORDS),
    .NUM_LINES  (NUM_LINES)
  ) u_array (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .rd_idx_i   (pc_idx),
    .rd_valid_o (rd_valid),
    .rd_tag_o   (rd_tag),
    .rd_line_o  (rd_line),
    .wr_en_i    (fill_en),
    .wr_idx_i   (fill_idx),
    .wr_tag_i   (fill_tag),
    .wr_line_i  (memData)
  );

  for (genvar gi = 0; gi < LINE_WORDS; gi++) begin : g_word
    assign line_words[gi] = rd_line[gi*WORD_W +: WORD_W];
  end

  assign tag_hit   = (state_q == RUN) && rd_valid && (rd_tag == pc_tag);
  assign hit       = tag_hit;
  assign instValid = tag_hit;
  assign inst      = line_words[pc_word];
  assign pcOut     = pc_q;
  assign memReq    = mem_req_q;
  assign memAddr   = mem_addr_q;

  always_comb begin
    state_d    = state_q;
    mem_addr_d = mem_addr_q;
    case (state_q)
      RUN: begin
        if (!tag_hit) begin
          state_d    = MISS_REQ;
          mem_addr_d = {pc_q[31:OFF_W], {OFF_W{1'b0}}};
        end
      end
      MISS_REQ:  if (memReady) state_d = MISS_WAIT;
      MISS_WAIT: if (memValid) state_d = RUN;
      default:   state_d = RUN;
    endcase
    mem_req_d = (state_d == MISS_REQ);
  end

  // A redirect wins in every state; an in-flight fill still lands at mem_addr_q.
  always_comb begin
    pc_d = pc_q;
    if (PCSrc) begin
      pc_d = {branchTarget[31:2], 2'b00};
    end else if (tag_hit && !stall) begin
      pc_d = pc_q + 32'd4;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      mem_addr_q <= '0;
      mem_req_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      mem_addr_q <= mem_addr_d;
      mem_req_q  <= mem_req_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (tag_hit && !stall && (hit_cnt_q != 32'hFFFF_FFFF)) begin
      hit_cnt_d = hit_cnt_q + 32'd1;
    end
    if ((state_q == RUN) && (state_d == MISS_REQ) && (miss_cnt_q != 32'hFFFF_FFFF)) begin
      miss_cnt_d = miss_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hitCount  = hit_cnt_q;
  assign missCount = miss_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_cache_unit.sv
// Directed bench for fetch_cache_unit: stimulus pushes expected fetches and
// fill requests into queues; a negedge monitor pops and compares them.
module tb_fetch_cache_unit;

  logic         Clk = 1'b0;
  logic         Rst_n = 1'b0;
  logic         PCSrc = 1'b0;
  logic [31:0]  branchTarget = '0;
  logic         stall = 1'b0;
  logic         memReady = 1'b0;
  logic         memValid = 1'b0;
  logic [127:0] memData = '0;
  logic [31:0]  inst, pcOut, memAddr;
  logic         instValid, hit, memReq;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]  hitCount, missCount;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  logic [63:0] inst_q [$];
  logic [31:0] addr_q [$];

  fetch_cache_unit #(
    .LINE_WORDS (4),
    .NUM_LINES  (16),
    .RESET_PC   (32'h0000_0000)
  ) dut (
    .Clk          (Clk),
    .Rst_n        (Rst_n),
    .PCSrc        (PCSrc),
    .branchTarget (branchTarget),
    .stall        (stall),
    .inst         (inst),
    .pcOut        (pcOut),
    .instValid    (instValid),
    .hit          (hit),
    .memReq       (memReq),
    .memAddr      (memAddr),
    .memReady     (memReady),
    .memValid     (memValid),
    .memData      (memData)
`ifdef FETCH_PERF_CNT_EN
    ,
    .hitCount     (hitCount),
    .missCount    (missCount)
`endif
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic push_inst(input logic [31:0] pc, input logic [31:0] word);
    inst_q.push_back({pc, word});
  endtask

  function automatic logic [127:0] mk_line(input logic [31:0] w0, input logic [31:0] w1,
                                           input logic [31:0] w2, input logic [31:0] w3);
    return {w3, w2, w1, w0};
  endfunction

  // Monitor: accepted instructions and accepted fill requests.
  always @(negedge Clk) begin : mon
    logic [63:0] e;
    logic [31:0] a;
    if (instValid && !stall) begin
      if (inst_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_inst: got pc %h inst %h, required no output", pcOut, inst);
      end else begin
        e = inst_q.pop_front();
        check("inst_pc", pcOut, e[63:32]);
        check("inst_word", inst, e[31:0]);
        check("hit_flag", {31'd0, hit}, 32'd1);
      end
    end
    if (memReq && memReady) begin
      if (addr_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_req: got memAddr %h, required no request", memAddr);
      end else begin
        a = addr_q.pop_front();
        check("req_addr", memAddr, a);
      end
    end
  end

  initial begin
    // Reset and cold miss on line 0
    repeat (3) cyc();
    check("rst_pc", pcOut, 32'h0);
    check("rst_memReq", {31'd0, memReq}, 32'd0);
    check("rst_memAddr", memAddr, 32'h0);
    check("rst_instValid", {31'd0, instValid}, 32'd0);
    Rst_n = 1'b1;                                   // C0
    #1;
    check("cold_instValid", {31'd0, instValid}, 32'd0);
    addr_q.push_back(32'h0);
    memReady = 1'b1;
    cyc();                                          // C1 MISS_REQ
    check("c1_memReq", {31'd0, memReq}, 32'd1);
    check("c1_memAddr", memAddr, 32'h0);
    cyc();                                          // C2 MISS_WAIT
    check("c2_memReq", {31'd0, memReq}, 32'd0);
    memReady = 1'b0;
    memValid = 1'b1;
    memData  = mk_line(32'h11, 32'h22, 32'h33, 32'h44);
    cyc();                                          // C3 RUN
    memValid = 1'b0;
    push_inst(32'h0, 32'h11);
    push_inst(32'h4, 32'h22);
    push_inst(32'h8, 32'h33);
    push_inst(32'hC, 32'h44);
    cyc();                                          // C4
    cyc();                                          // C5
    cyc();                                          // C6 PC 0xC, hot loop back to 0
    check("c6_pc", pcOut, 32'hC);
    PCSrc = 1'b1;
    branchTarget = 32'h0000_0003;
    push_inst(32'h0, 32'h11);
    push_inst(32'h4, 32'h22);
    push_inst(32'h8, 32'h33);
    cyc();                                          // C7
    PCSrc = 1'b0;
    check("loop_pc", pcOut, 32'h0);
    check("loop_noreq", {31'd0, memReq}, 32'd0);
`ifdef FETCH_PERF_CNT_EN
    check("hitCount", hitCount, 32'd4);
    check("missCount", missCount, 32'd1);
`endif
    // Stall on PC 0x4 for three cycles
    cyc();                                          // C8
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("stall_pc", pcOut, 32'h4);
      check("stall_inst", inst, 32'h22);
      cyc();                                        // C9..C11
    end
    stall = 1'b0;
    check("unstall_pc", pcOut, 32'h4);
    cyc();                                          // C12
    check("resume_pc", pcOut, 32'h8);
    PCSrc = 1'b1;
    branchTarget = 32'h40;
    cyc();                                          // C13 miss at 0x40
    PCSrc = 1'b0;
    check("m40_instValid", {31'd0, instValid}, 32'd0);
    addr_q.push_back(32'h40);
    memReady = 1'b1;
    cyc();                                          // C14 MISS_REQ
    check("m40_memAddr", memAddr, 32'h40);
    cyc();                                          // C15 MISS_WAIT, redirect to cached 0x0
    memReady = 1'b0;
    PCSrc = 1'b1;
    branchTarget = 32'h0;
    cyc();                                          // C16
    PCSrc = 1'b0;
    check("redir_pc", pcOut, 32'h0);
    check("redir_instValid", {31'd0, instValid}, 32'd0);
    memValid = 1'b1;
    memData  = mk_line(32'h55, 32'h66, 32'h77, 32'h88);
    cyc();                                          // C17 RUN at 0x0
    memValid = 1'b0;
    push_inst(32'h0, 32'h11);
    PCSrc = 1'b1;
    branchTarget = 32'h44;
    cyc();                                          // C18 0x44 hits filled line
    push_inst(32'h44, 32'h66);
    branchTarget = 32'h100;
    cyc();                                          // C19 miss at 0x100
    PCSrc = 1'b0;
    check("m100_instValid", {31'd0, instValid}, 32'd0);
    addr_q.push_back(32'h100);
    for (int i = 0; i < 6; i++) begin
      cyc();                                        // C20..C25
      check("hold_memReq", {31'd0, memReq}, 32'd1);
      check("hold_memAddr", memAddr, 32'h100);
    end
    memReady = 1'b1;                                // accepted in C25
    cyc();                                          // C26 MISS_WAIT
    memReady = 1'b0;
    memValid = 1'b1;
    memData  = mk_line(32'hA1, 32'hA2, 32'hA3, 32'hA4);
    cyc();                                          // C27 RUN at 0x100
    memValid = 1'b0;
    push_inst(32'h100, 32'hA1);
    PCSrc = 1'b1;
    branchTarget = 32'h0;
    cyc();                                          // C28 0x0 evicted
    PCSrc = 1'b0;
    check("evict_instValid", {31'd0, instValid}, 32'd0);
    addr_q.push_back(32'h0);
    memReady = 1'b1;
    cyc();                                          // C29 MISS_REQ
    check("evict_memAddr", memAddr, 32'h0);
    cyc();                                          // C30 MISS_WAIT
    memReady = 1'b0;
    memValid = 1'b1;
    memData  = mk_line(32'h11, 32'h22, 32'h33, 32'h44);
    cyc();                                          // C31 RUN at 0x0
    memValid = 1'b0;
    push_inst(32'h0, 32'h11);
    PCSrc = 1'b1;
    branchTarget = 32'h200;
    cyc();                                          // C32 miss at 0x200
    PCSrc = 1'b0;
    check("m200_instValid", {31'd0, instValid}, 32'd0);
    addr_q.push_back(32'h200);
    memReady = 1'b1;
    cyc();                                          // C33 MISS_REQ
    check("m200_memAddr", memAddr, 32'h200);
    cyc();                                          // C34 MISS_WAIT, reset mid-fill
    memReady = 1'b0;
    Rst_n = 1'b0;
    #1;
    check("mrst_pc", pcOut, 32'h0);
    check("mrst_memReq", {31'd0, memReq}, 32'd0);
    check("mrst_memAddr", memAddr, 32'h0);
    check("mrst_instValid", {31'd0, instValid}, 32'd0);
    cyc();
    Rst_n = 1'b1;                                   // R0, late fill data arrives
    memValid = 1'b1;
    memData  = mk_line(32'hDEAD_0000, 32'hDEAD_0001, 32'hDEAD_0002, 32'hDEAD_0003);
    #1;
    check("post_rst_instValid", {31'd0, instValid}, 32'd0);
    cyc();                                          // R1 new miss for 0x0
    memValid = 1'b0;
    check("post_rst_memReq", {31'd0, memReq}, 32'd1);
    check("post_rst_memAddr", memAddr, 32'h0);
    addr_q.push_back(32'h0);
    memReady = 1'b1;
    cyc();                                          // R2 MISS_WAIT
    memReady = 1'b0;
    memValid = 1'b1;
    memData  = mk_line(32'h11, 32'h22, 32'h33, 32'h44);
    cyc();                                          // R3 RUN
    memValid = 1'b0;
    push_inst(32'h0, 32'h11);
    cyc();                                          // R4
    stall = 1'b1;
    check("final_pc", pcOut, 32'h4);
    repeat (2) cyc();
    check("inst_q_drained", inst_q.size(), 32'd0);
    check("addr_q_drained", addr_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_cache_unit.md
# fetch_cache_unit

Parametrised instruction-fetch stage: PC register, sequential/branch next-PC selection, a direct-mapped instruction cache, and a miss FSM that refills whole lines from instruction memory over a valid/ready handshake of arbitrary latency. It sits at the front of the pipeline, feeding `inst`/`pcOut` to decode. Unlike the fixed single-cycle fetch path, it supports configurable line/cache geometry, downstream stall, and multi-cycle memory.

## Interface
- `LINE_WORDS`, 4, 32-bit words per cache line (power of 2, ≥2)
- `NUM_LINES`, 16, cache lines (power of 2, ≥2)
- `RESET_PC`, 32'h0000_0000, PC after reset (word-aligned)
- `Clk` in 1, rising-edge clock
- `Rst_n` in 1, asynchronous active-low reset
- `PCSrc` in 1, redirect to `branchTarget` this cycle
- `branchTarget` in 32, redirect address; bits [1:0] ignored (treated as 0)
- `stall` in 1, decode cannot accept; hold PC
- `inst` out 32, instruction word at `pcOut`; valid only when `instValid`
- `pcOut` out 32, current fetch PC
- `instValid` out 1, `inst` is valid this cycle
- `hit` out 1, tag match for `pcOut` in RUN
- `memReq` out 1, line-fill request valid
- `memAddr` out 32, line-aligned fill address
- `memReady` in 1, memory accepts request
- `memValid` in 1, fill data valid
- `memData` in 32*LINE_WORDS, fill line; word 0 in bits [31:0]
- `hitCount`, `missCount` out 32 each (only with `FETCH_PERF_CNT_EN`)

## Operation
- Address split: OFF_W = 2+log2(LINE_WORDS); IDX_W = log2(NUM_LINES); index = pcOut[OFF_W+IDX_W-1:OFF_W]; word = pcOut[OFF_W-1:2]; tag = pcOut[31:OFF_W+IDX_W].
- States: RUN, MISS_REQ, MISS_WAIT.
- RUN: combinational lookup; `hit` = valid[index] && tag match; `instValid` = `hit`. Miss → MISS_REQ next cycle, latching `memAddr` = {pcOut[31:OFF_W], OFF_W'b0}.
- MISS_REQ: `memReq`=1, `memAddr` stable until `memReady`; on `memReady` → MISS_WAIT. Request is never withdrawn once raised.
- MISS_WAIT: `memReq`=0; on `memValid` write line, tag, valid[index]=1 → RUN. `memValid` outside MISS_WAIT ignored.
- `hit`, `instValid` forced 0 outside RUN.
- Next PC, priority order: `PCSrc` → {branchTarget[31:2],2'b00} (any state, regardless of `stall`); else RUN && `instValid` && !`stall` → pcOut+4 (wraps mod 2^32); else hold.
- Redirect during MISS_REQ/MISS_WAIT: PC updates immediately; the outstanding fill completes and is written to the line of the latched `memAddr`; RUN then looks up the new PC.
- Reset: PC=RESET_PC, state RUN, all valid bits 0, `memReq`=0, `memAddr`=0, `hit`=`instValid`=0; tags/data need no reset. Reset mid-miss abandons the fill; a late `memValid` is ignored.

## Timing
- Hit: zero-latency — `inst` valid in the same cycle `pcOut` is presented; one instruction per cycle when unstalled.
- Miss detected at cycle N (`instValid`=0); `memReq`=1 from N+1; accepted at cycle A ≥ N+1; fill at cycle F > A; RUN with `instValid`=1 at F+1. Minimum miss penalty is 3 cycles (`memReady` at N+1, `memValid` at N+2).
- `memAddr`, `memReq` registered; `inst`, `hit`, `instValid` combinational from registered state.

## Configuration
- `FETCH_PERF_CNT_EN` defined: `hitCount` increments on each accepted instruction (`instValid` && !`stall`); `missCount` increments on each RUN→MISS_REQ transition; both saturate at 32'hFFFF_FFFF and reset to 0.
- Undefined: ports and counters absent; functional behaviour otherwise identical.

## Structure
- Package `fetch_pkg`: state enum (RUN, MISS_REQ, MISS_WAIT), word-width constant 32, `clog2`-based OFF_W/IDX_W/TAG_W helper functions.
- Sub-module `icache_array`: valid/tag/data storage, combinational read by index, one synchronous line-write port, async clear of valid bits on `Rst_n`.

## Test plan
- Reset, RESET_PC=0, cold cache: `instValid`=0, `memReq`=1 with `memAddr`=0 next cycle; `memReady` at once, fill with words 0x11,0x22,0x33,0x44 two cycles later → `inst`=0x11, 0x22, 0x33, 0x44 on consecutive cycles, PC 0→0xC.
- Hot loop: `PCSrc` to 0x0 at PC 0xC → `inst`=0x11 same-cycle hit, no `memReq`; `hitCount` increments, `missCount` unchanged.
- Stall on a hit at PC 0x4 for 3 cycles → `pcOut`=0x4, `inst`=0x22 held; resumes 0x8 the cycle after `stall` drops.
- Redirect in MISS_WAIT to 0x0 (cached) while fill for 0x40 is pending → `pcOut`=0x0 immediately, `instValid`=0 until fill lands, then `inst`=0x11; later lookup at 0x40 hits.
- `memReady` low 5 cycles → `memReq`/`memAddr` stable throughout; conflict: 0x100 (same index as 0x0, LINE_WORDS=4, NUM_LINES=16) evicts 0x0, next fetch of 0x0 misses.
- Assert `Rst_n` low in MISS_WAIT, then `memValid` after release → ignored, valid bits clear, `pcOut`=RESET_PC, new miss raised.
